// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared types and encodings for the MEM-stage load/store sequencer.
package mem_pkg;

  typedef enum logic [2:0] {StIdle, StRd, StWait, StCap, StWr, StResp} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_WR   = 2'b01;
  localparam logic [1:0] MEM_RD   = 2'b10;

  // Illegal width codes, unsigned stores and misaligned halfword/word accesses all fault.
  function automatic logic lsu_fault(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    return 1'b0;
      F3_H:    return addr_lo[0];
      F3_W:    return addr_lo != 2'b00;
      F3_BU:   return we;
      F3_HU:   return we | addr_lo[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_ctrl_if.sv
// Pipeline request/response and data-memory bus of the load/store sequencer.
interface mem_lsu_ctrl_if;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misalign;
  logic [31:0] o_memAddr;
  logic [1:0]  o_ctrlMEM;
  logic [31:0] o_writeData;
  logic [31:0] i_memReadData;

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_memReadData,
    input  o_stall, o_done, o_rdata, o_misalign, o_memAddr, o_ctrlMEM, o_writeData
  );

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_memReadData,
    output o_stall, o_done, o_rdata, o_misalign, o_memAddr, o_ctrlMEM, o_writeData
  );
endinterface

// File: rtl/mem_lsu_ctrl_lane_align.sv
// Combinational lane extraction for loads and byte/halfword merge for stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase

    store_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        store_o = word_i;
        store_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_H: begin
        store_o = word_i;
        store_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Load/store sequencer: stalls the MEM stage while it runs a read, write or
// read-modify-write against word-addressed data memory.
module mem_lsu_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input logic           i_clk,
  input logic           i_reset,
  mem_lsu_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(READ_LAT + 1);

  lsu_state_t      state_q, state_d;
  logic            we_q, fault_q;
  logic [2:0]      funct3_q;
  logic [31:0]     addr_q, result_q, wword_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     load_val, store_word;
  logic            req_fault;

  assign req_fault = lsu_fault(bus.i_we, bus.i_funct3, bus.i_addr[1:0]);

  // wword_q holds the raw store data until CAP replaces it with the merged word.
  mem_lane_align u_lane_align (
    .funct3_i (funct3_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (bus.i_memReadData),
    .wdata_i  (wword_q),
    .load_o   (load_val),
    .store_o  (store_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_req) begin
          if (req_fault)                     state_d = StResp;
          else if (bus.i_we && bus.i_funct3 == F3_W) state_d = StWr;
          else                               state_d = StRd;
        end
      end
      StRd:    state_d = (READ_LAT > 1) ? StWait : StCap;
      StWait:  if (cnt_q == CntW'(1)) state_d = StCap;
      StCap:   state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      result_q <= 32'd0;
      wword_q  <= 32'd0;
      cnt_q    <= '0;
    end else begin
      if (state_q == StIdle && bus.i_req) begin
        we_q     <= bus.i_we;
        fault_q  <= req_fault;
        funct3_q <= bus.i_funct3;
        addr_q   <= bus.i_addr;
        wword_q  <= bus.i_wdata;
      end
      if (state_q == StRd)        cnt_q <= CntW'(READ_LAT - 1);
      else if (state_q == StWait) cnt_q <= cnt_q - CntW'(1);
      if (state_q == StCap) begin
        if (we_q) wword_q  <= store_word;
        else      result_q <= load_val;
      end
    end
  end

  always_comb begin
    bus.o_ctrlMEM   = MEM_IDLE;
    bus.o_memAddr   = 32'd0;
    bus.o_writeData = 32'd0;
    bus.o_done      = 1'b0;
    bus.o_rdata     = 32'd0;
    bus.o_misalign  = 1'b0;
    unique case (state_q)
      StRd: begin
        bus.o_ctrlMEM = MEM_RD;
        bus.o_memAddr = {addr_q[31:2], 2'b00};
      end
      StWr: begin
        bus.o_ctrlMEM   = MEM_WR;
        bus.o_memAddr   = {addr_q[31:2], 2'b00};
        bus.o_writeData = wword_q;
      end
      StResp: begin
        bus.o_done     = 1'b1;
        bus.o_misalign = fault_q;
        bus.o_rdata    = (we_q || fault_q) ? 32'd0 : result_q;
      end
      default: ;
    endcase
    bus.o_stall = bus.i_req & (state_q != StResp);
  end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Scoreboard bench: two sequencer instances (read latency 1 and 3) with memory models.
module tb_mem_lsu_ctrl;

  typedef struct {int cyc; logic [31:0] rdata; logic mis;} resp_t;
  typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  resp_t rq[$];
  resp_t rq3[$];
  ev_t   rdq[$];
  ev_t   wrq[$];
  resp_t r1, r3;
  ev_t   e1;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic        poke1_en = 1'b0, poke3_en = 1'b0;
  logic [7:0]  poke_idx = 8'd0;
  logic [31:0] poke_val = 32'd0;
  logic [31:0] s0, s1;

  mem_lsu_ctrl_if bus1 ();
  mem_lsu_ctrl_if bus3 ();

  mem_lsu_ctrl #(.READ_LAT(1)) u_dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1));
  mem_lsu_ctrl #(.READ_LAT(3)) u_dut3 (.i_clk(clk), .i_reset(rst), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: registered read data, valid only exactly READ_LAT cycles after the strobe.
  always @(posedge clk) begin
    if (poke1_en) mem1[poke_idx] <= poke_val;
    if (bus1.o_ctrlMEM == 2'b01) mem1[bus1.o_memAddr[9:2]] <= bus1.o_writeData;
    bus1.i_memReadData <= (bus1.o_ctrlMEM == 2'b10) ? mem1[bus1.o_memAddr[9:2]] : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (poke3_en) mem3[poke_idx] <= poke_val;
    if (bus3.o_ctrlMEM == 2'b01) mem3[bus3.o_memAddr[9:2]] <= bus3.o_writeData;
    s0 <= (bus3.o_ctrlMEM == 2'b10) ? mem3[bus3.o_memAddr[9:2]] : 32'hBAD0_BAD0;
    s1 <= s0;
    bus3.i_memReadData <= s1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor for the latency-1 instance: responses and every memory-bus cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus1.o_done) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected cyc=%0d got rdata=%h mis=%b required none",
                   cyc, bus1.o_rdata, bus1.o_misalign);
        end else begin
          r1 = rq.pop_front();
          if (cyc != r1.cyc || bus1.o_rdata !== r1.rdata || bus1.o_misalign !== r1.mis) begin
            errors++;
            $display("FAIL resp cyc=%0d rdata=%h mis=%b required cyc=%0d rdata=%h mis=%b",
                     cyc, bus1.o_rdata, bus1.o_misalign, r1.cyc, r1.rdata, r1.mis);
          end
        end
      end
      checks++;
      case (bus1.o_ctrlMEM)
        2'b10: begin
          if (rdq.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected cyc=%0d addr=%h required none", cyc, bus1.o_memAddr);
          end else begin
            e1 = rdq.pop_front();
            if (cyc != e1.cyc || bus1.o_memAddr !== e1.addr || bus1.o_writeData !== 32'd0) begin
              errors++;
              $display("FAIL read cyc=%0d addr=%h wd=%h required cyc=%0d addr=%h wd=0",
                       cyc, bus1.o_memAddr, bus1.o_writeData, e1.cyc, e1.addr);
            end
          end
        end
        2'b01: begin
          if (wrq.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected cyc=%0d addr=%h data=%h required none",
                     cyc, bus1.o_memAddr, bus1.o_writeData);
          end else begin
            e1 = wrq.pop_front();
            if (cyc != e1.cyc || bus1.o_memAddr !== e1.addr || bus1.o_writeData !== e1.data) begin
              errors++;
              $display("FAIL write cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                       cyc, bus1.o_memAddr, bus1.o_writeData, e1.cyc, e1.addr, e1.data);
            end
          end
        end
        2'b00: begin
          if (bus1.o_memAddr !== 32'd0 || bus1.o_writeData !== 32'd0) begin
            errors++;
            $display("FAIL idle_bus cyc=%0d addr=%h wd=%h required 0 0",
                     cyc, bus1.o_memAddr, bus1.o_writeData);
          end
        end
        default: begin
          errors++;
          $display("FAIL ctrl cyc=%0d got=%b required not 11", cyc, bus1.o_ctrlMEM);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en && bus3.o_done) begin
      checks++;
      if (rq3.size() == 0) begin
        errors++;
        $display("FAIL resp3_unexpected cyc=%0d got rdata=%h required none", cyc, bus3.o_rdata);
      end else begin
        r3 = rq3.pop_front();
        if (cyc != r3.cyc || bus3.o_rdata !== r3.rdata || bus3.o_misalign !== r3.mis) begin
          errors++;
          $display("FAIL resp3 cyc=%0d rdata=%h mis=%b required cyc=%0d rdata=%h mis=%b",
                   cyc, bus3.o_rdata, bus3.o_misalign, r3.cyc, r3.rdata, r3.mis);
        end
      end
    end
  end

  task automatic poke(input bit sel3, input logic [7:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    poke_idx = idx;
    poke_val = val;
    if (sel3) poke3_en = 1'b1;
    else      poke1_en = 1'b1;
    @(posedge clk); #1;
    poke1_en = 1'b0;
    poke3_en = 1'b0;
  endtask

  // lat: done cycle relative to accept; wr_off: write cycle relative to accept (0 = none).
  task automatic op1(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                     input int lat, input int wr_off, input logic [31:0] exp_wr);
    int c0;
    bit seen;
    @(posedge clk); #1;
    bus1.i_req    = 1'b1;
    bus1.i_we     = we;
    bus1.i_funct3 = f3;
    bus1.i_addr   = a;
    bus1.i_wdata  = wd;
    c0 = cyc;
    rq.push_back('{c0 + lat, exp_rd, exp_mis});
    if (!exp_mis && !(we && f3 == 3'b010)) rdq.push_back('{c0 + 1, {a[31:2], 2'b00}, 32'd0});
    if (wr_off > 0) wrq.push_back('{c0 + wr_off, {a[31:2], 2'b00}, exp_wr});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus1.o_done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout f3=%b addr=%h got no done required done", f3, a);
    end
    @(posedge clk); #1;
    bus1.i_req = 1'b0;
  endtask

  initial begin
    int c0;
    bus1.i_req = 1'b0; bus1.i_we = 1'b0; bus1.i_funct3 = 3'd0;
    bus1.i_addr = 32'd0; bus1.i_wdata = 32'd0;
    bus3.i_req = 1'b0; bus3.i_we = 1'b0; bus3.i_funct3 = 3'd0;
    bus3.i_addr = 32'd0; bus3.i_wdata = 32'd0;

    poke(1'b0, 8'd16, 32'h8877_66F5);
    @(negedge clk);
    chk("rst_done", {31'd0, bus1.o_done}, 32'd0);
    chk("rst_ctrl", {30'd0, bus1.o_ctrlMEM}, 32'd0);
    chk("rst_addr", bus1.o_memAddr, 32'd0);
    chk("rst_rdata", bus1.o_rdata, 32'd0);
    chk("rst_mis", {31'd0, bus1.o_misalign}, 32'd0);
    chk("rst_done3", {31'd0, bus3.o_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    op1(1'b0, 3'b000, 32'h40, 32'd0, 32'hFFFF_FFF5, 1'b0, 3, 0, 32'd0);
    op1(1'b0, 3'b100, 32'h40, 32'd0, 32'h0000_00F5, 1'b0, 3, 0, 32'd0);
    op1(1'b0, 3'b001, 32'h42, 32'd0, 32'hFFFF_8877, 1'b0, 3, 0, 32'd0);
    op1(1'b0, 3'b101, 32'h40, 32'd0, 32'h0000_66F5, 1'b0, 3, 0, 32'd0);

    poke(1'b0, 8'd16, 32'h1122_3344);
    op1(1'b1, 3'b000, 32'h41, 32'hFFFF_FFAB, 32'd0, 1'b0, 4, 3, 32'h1122_AB44);
    chk("mem_after_sb", mem1[16], 32'h1122_AB44);
    op1(1'b1, 3'b001, 32'h42, 32'h1234_BEEF, 32'd0, 1'b0, 4, 3, 32'hBEEF_AB44);
    op1(1'b1, 3'b010, 32'h80, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1, 32'hDEAD_BEEF);
    op1(1'b0, 3'b010, 32'h80, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 0, 32'd0);
    op1(1'b0, 3'b000, 32'h81, 32'd0, 32'hFFFF_FFBE, 1'b0, 3, 0, 32'd0);
    op1(1'b0, 3'b101, 32'h82, 32'd0, 32'h0000_DEAD, 1'b0, 3, 0, 32'd0);

    op1(1'b0, 3'b010, 32'h42, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0);
    op1(1'b1, 3'b001, 32'h43, 32'h1234, 32'd0, 1'b1, 1, 0, 32'd0);
    op1(1'b0, 3'b011, 32'h40, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0);
    op1(1'b1, 3'b100, 32'h40, 32'h12, 32'd0, 1'b1, 1, 0, 32'd0);

    // SB reset while in CAP: the read happens, the write must never appear.
    @(posedge clk); #1;
    bus1.i_req = 1'b1; bus1.i_we = 1'b1; bus1.i_funct3 = 3'b000;
    bus1.i_addr = 32'h41; bus1.i_wdata = 32'h55;
    c0 = cyc;
    rdq.push_back('{c0 + 1, 32'h40, 32'd0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus1.i_req = 1'b0;
    @(negedge clk);
    chk("rstcap_done", {31'd0, bus1.o_done}, 32'd0);
    chk("rstcap_ctrl", {30'd0, bus1.o_ctrlMEM}, 32'd0);
    chk("rstcap_addr", bus1.o_memAddr, 32'd0);
    chk("rstcap_wd", bus1.o_writeData, 32'd0);
    chk("rstcap_stall", {31'd0, bus1.o_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("rstcap_mem", mem1[16], 32'hBEEF_AB44);
    op1(1'b0, 3'b000, 32'h43, 32'd0, 32'hFFFF_FFBE, 1'b0, 3, 0, 32'd0);

    // Latency 3, request held across two back-to-back word loads.
    poke(1'b1, 8'd32, 32'hCAFE_F00D);
    poke(1'b1, 8'd33, 32'h0BAD_F00D);
    @(posedge clk); #1;
    bus3.i_req = 1'b1; bus3.i_we = 1'b0; bus3.i_funct3 = 3'b010; bus3.i_addr = 32'h80;
    c0 = cyc;
    rq3.push_back('{c0 + 5, 32'hCAFE_F00D, 1'b0});
    rq3.push_back('{c0 + 11, 32'h0BAD_F00D, 1'b0});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("stall3", {31'd0, bus3.o_stall}, (k == 5 || k == 11) ? 32'd0 : 32'd1);
      if (k == 5) begin
        @(posedge clk); #1;
        bus3.i_addr = 32'h84;
      end
    end
    @(posedge clk); #1;
    bus3.i_req = 1'b0;
    repeat (3) @(posedge clk);

    chk("resp_left", rq.size(), 32'd0);
    chk("resp3_left", rq3.size(), 32'd0);
    chk("reads_left", rdq.size(), 32'd0);
    chk("writes_left", wrq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu_ctrl.md
# mem_lsu_ctrl

Load/store sequencer between the MEM pipeline stage and the word-addressed data memory. Accepts one RISC-V load/store per transaction, stalls the pipeline while it runs, and drives the memory's address, write data and 2-bit read/write control. Word accesses pass straight through. Byte and halfword stores run as read-modify-write. Loads are lane-extracted with sign or zero extension. Misaligned and illegal accesses are flagged and never reach memory.

## Interface
Parameters:
- READ_LAT, 1: cycles from a read strobe to valid `i_memReadData`; legal range 1–4.

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req  in  1  transaction request; held with operands stable until `o_done`
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned
- o_stall  out  1  pipeline stall
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  load result, valid while `o_done`
- o_misalign  out  1  access fault, valid while `o_done`
- o_memAddr  out  32  word-aligned memory address
- o_ctrlMEM  out  2  {mem-read, mem-write}
- o_writeData  out  32  memory write word
- i_memReadData  in  32  memory read word

## Operation
States: IDLE, RD, WAIT, CAP, WR, RESP.

**IDLE**
- On `i_req`, latch `i_we`, `i_funct3`, `i_addr`, `i_wdata`.
- Next state by access type:
  - illegal or misaligned → RESP
  - SW → WR
  - all other accesses → RD

**Access checks**
- Illegal:
  - `i_funct3` not in {000, 001, 010, 100, 101}
  - store with `i_funct3` = 100 or 101
- Misaligned:
  - halfword with `addr[0]` = 1
  - word with `addr[1:0]` ≠ 00

**RD**
- `o_ctrlMEM` = 10, one cycle.
- Next: WAIT if READ_LAT > 1, else CAP.

**WAIT**
- Held for READ_LAT−1 cycles, then CAP.

**CAP**
- Sample `i_memReadData`, which is READ_LAT cycles after RD.
- Loads: extract the lane into the result register, then RESP.
  - Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- SB/SH: merge `i_wdata[7:0]` or `i_wdata[15:0]` into the sampled word at the lane, register it as the write word, then WR.

**WR**
- `o_ctrlMEM` = 01 and `o_writeData` = write word, one cycle, then RESP.
- For SW the write word is the latched `i_wdata`.

**RESP**
- `o_done` = 1, then IDLE.
- `o_rdata` = result register (loads), 0 for stores and faults.
- `o_misalign` = 1 for a fault.

**Combinational outputs**
- `o_stall` = `i_req` & ~`o_done`.
- `o_memAddr` = {addr[31:2], 2'b00} in RD and WR, 0 otherwise.
- `o_writeData` = 0 outside WR.
- `o_ctrlMEM` is never 11 and is 00 outside RD and WR.

## Timing
- Accept cycle = c0. Done cycle by type:
  - Fault: done at c1; no memory access.
  - SW: WR at c1, done at c2.
  - Loads: RD at c1, CAP at c1+READ_LAT, done at c2+READ_LAT.
  - SB/SH: RD at c1, WR at c2+READ_LAT, done at c3+READ_LAT.
- Back-to-back requests: RESP always returns to IDLE. A request still high in the cycle after `o_done` is a new transaction, so there is one cycle between completion and the next accept.
- `i_req` dropped mid-transaction is ignored; the transaction completes.
- Reset values: state IDLE; `o_done`, `o_misalign`, `o_rdata`, result and write-word registers all 0; `o_ctrlMEM` 00; `o_memAddr` 0.
- Reset mid-operation takes effect at the next edge. A transaction reset in RD, WAIT or CAP issues no write. A write issued in WR in the same cycle as reset is not retracted.

## Structure
- Package `mem_pkg` holds:
  - `lsu_state_t` enum
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - ctrlMEM encodings (MEM_IDLE = 00, MEM_WR = 01, MEM_RD = 10)
- Sub-module `mem_lane_align`, purely combinational: (funct3, addr[1:0], word, wdata) → {load value, merged store word}. Instanced once; shared by the CAP load and store paths.
- Wait counter: $clog2(READ_LAT+1) bits.

## Test plan
- Memory word 0x40 = 0x8877_66F5; LB at 0x40 → `o_rdata` 0xFFFF_FFF5, `o_done` at c3 (READ_LAT = 1); LBU at 0x40 → 0x0000_00F5; LH at 0x42 → 0xFFFF_8877.
- Word 0x40 = 0x1122_3344; SB 0xAB at 0x41 → WR at c3 with `o_writeData` 0x1122_AB44, `o_done` c4; `o_ctrlMEM` sequence 00,10,00,01,00.
- SW 0xDEAD_BEEF at 0x80 → `o_ctrlMEM` 01 at c1, `o_memAddr` 0x80, `o_done` c2; subsequent LW at 0x80 → 0xDEAD_BEEF.
- LW at 0x42, SH at 0x43, and funct3 = 011 → `o_misalign` = 1 and `o_done` at c1, `o_ctrlMEM` = 00 throughout, `o_rdata` = 0.
- SB at 0x41 with `i_reset` asserted during CAP → no 01 strobe ever issued; memory word unchanged; outputs at reset values next cycle.
- READ_LAT = 3, LW held back-to-back → `o_done` at c5, next accept at c6; `o_stall` high c0–c4 and low at c5.
